bcd_serial_adder: RTL and testbench
===================================

# bcd_serial_adder

Parametrised N-digit BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first, behind a Start/Busy/Done handshake. It replaces the fixed two-digit combinational BCD adder on the board datapath. Results are held stable for the seven-segment decode stage, and invalid (non-decimal) operand digits are flagged. It sits between the switch/operand registers and the per-digit hex display decoders.

## Interface
- DIGITS, 4: number of BCD digits per operand and result (≥1)
- Clock  input  1  single system clock, rising-edge
- Reset  input  1  asynchronous, active-high; clears all state and outputs
- Start  input  1  request an operation; sampled only in IDLE
- Sub  input  1  0 = A+B, 1 = A−B; captured with Start
- A  input  4*DIGITS  operand A, digit i at bits [4i+3:4i]
- B  input  4*DIGITS  operand B, same packing
- Sum  output  4*DIGITS  result digits, same packing
- Cout  output  1  add: decimal carry out; sub: borrow (1 when A<B)
- Invalid  output  1  some captured operand digit was >9
- Busy  output  1  high while digits are being processed
- Done  output  1  one-cycle pulse when Sum/Cout/Invalid are updated

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE: on a rising edge with Start=1, latch A, B, Sub and check all 2*DIGITS digits. If any digit >9, go to FIN with invalid pending. Otherwise clear the digit index, set carry-in = Sub, and go to RUN.
- RUN: each cycle, add digit i of A to digit i of B' and the carry. B' = B for add, or the nines-complement (9−b) for sub.
  - Binary digit sum s = a + b' + c, 0..19.
  - If s > 9: digit = s − 10 (s + 6 mod 16) and carry = 1; else digit = s and carry = 0.
  - The digit is written into a working register. The index increments; after digit DIGITS−1, go to FIN.
- FIN, one cycle:
  - Copy the working register to Sum.
  - Add: Cout = final carry. Sub: Cout = ~final carry.
  - Invalid = pending flag. When invalid: Sum = 0 and Cout = 0.
  - Done = 1. Return to IDLE.
- A negative subtraction leaves the ten's-complement magnitude in Sum with Cout = 1. No sign-magnitude conversion is done.
- Sum, Cout and Invalid hold their last values until the next FIN. They do not change during RUN.
- Start while in RUN or FIN is ignored, with no queuing. A, B and Sub changing after capture have no effect.

## Timing
- Reset values: Sum = 0, Cout = 0, Invalid = 0, Busy = 0, Done = 0, state IDLE, working registers 0.
- Start sampled high at edge k (valid operands) gives:
  - Busy high from after edge k to after edge k+DIGITS
  - Done high for exactly the cycle after edge k+DIGITS+1, with outputs updated on that edge
  - Latency Start→Done: DIGITS+1 edges
- Invalid operands: Done and Invalid update on edge k+1. Busy never asserts.
- Back-to-back operation: the next Start is accepted the cycle Done is high (state is IDLE). Throughput is one operation per DIGITS+2 cycles.
- Reset asserted mid-RUN aborts immediately and asynchronously. Outputs go to reset values, no Done is generated, and the next operation needs a fresh Start.
- DIGITS=1 is legal: Busy for 1 cycle, Done on edge k+2.

## Structure
- Package bcd_pkg holds:
  - the state enum (IDLE, RUN, FIN)
  - the bcd_digit_t typedef (logic [3:0])
  - the constants BCD_MAX = 9 and BCD_ADJ = 6
- Sub-module bcd_digit_add: combinational one-digit adder with ports a, b, cin, sum, cout. It applies the +6 correction and is instantiated once and reused each RUN cycle.
- Top-level: FSM, a digit index counter of width $clog2(DIGITS+1), operand shift/select, working register, and output registers.

## Test plan
All scenarios use DIGITS=4.
- Add 4567 + 5678: Sum = 0x0245, Cout = 1, Done on edge k+5, Busy for 4 cycles.
- Add 9999 + 0001: Sum = 0x0000, Cout = 1. Add 1234 + 4321: Sum = 0x5555, Cout = 0.
- Sub 1000 − 0001: Sum = 0x0999, Cout = 0. Sub 0001 − 0002: Sum = 0x9999, Cout = 1 (ten's complement of −1).
- A = 0x00A0, B = 0x0001, Start: Invalid = 1, Sum = 0, Cout = 0, Done on edge k+1, Busy stays 0. The next valid add clears Invalid.
- Start pulsed again during RUN with different operands: ignored, and the first result is unaffected. Start in the Done cycle is accepted.
- Reset asserted two cycles into RUN: all outputs 0 immediately and no Done pulse. A following 0012 + 0034 gives Sum = 0x0046.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder/subtractor.
`timescale 1ns/1ps
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_ADJ = 4'd6;

  function automatic logic is_bcd(input bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit decimal adder: binary add, then +6 correction when the sum exceeds 9.
`timescale 1ns/1ps
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    cout = raw > {1'b0, BCD_MAX};
    // Adding 6 modulo 16 is the same as subtracting 10 for raw in 10..19.
    sum  = cout ? bcd_digit_t'(raw[3:0] + BCD_ADJ) : raw[3:0];
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// N-digit BCD adder/subtractor, one digit per clock LSD first, Start/Busy/Done handshake.
`timescale 1ns/1ps
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Sub,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  output logic [4*DIGITS-1:0] Sum,
  output logic                Cout,
  output logic                Invalid,
  output logic                Busy,
  output logic                Done
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
  logic               sub_q, sub_d, carry_q, carry_d, inv_q, inv_d;
  logic               cout_q, cout_d, invalid_q, invalid_d, done_q, done_d;

  bcd_digit_t a_dig, b_dig, b_eff, dig_sum;
  logic       dig_cout, ops_ok;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    // Subtraction adds the nines-complement; the initial carry of 1 completes ten's complement.
    b_eff = sub_q ? bcd_digit_t'(BCD_MAX - b_dig) : b_dig;
  end

  bcd_digit_add u_digit_add (
    .a    (a_dig),
    .b    (b_eff),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  always_comb begin
    ops_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(A[4*i +: 4]) || !is_bcd(B[4*i +: 4])) ops_ok = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    work_d    = work_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    inv_d     = inv_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          sub_d   = Sub;
          idx_d   = '0;
          carry_d = Sub;
          work_d  = '0;
          inv_d   = !ops_ok;
          state_d = ops_ok ? RUN : FIN;
        end
      end
      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) work_d[4*i +: 4] = dig_sum;
        end
        carry_d = dig_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(DIGITS - 1)) state_d = FIN;
      end
      FIN: begin
        done_d    = 1'b1;
        invalid_d = inv_q;
        sum_d     = inv_q ? '0 : work_q;
        cout_d    = inv_q ? 1'b0 : (sub_q ? ~carry_q : carry_q);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      // NOTE: operand and working registers are reset too; the block must come up fully cleared.
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      inv_q     <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      work_q    <= work_d;
      sub_q     <= sub_d;
      carry_q   <= carry_d;
      inv_q     <= inv_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
      done_q    <= done_d;
    end
  end

  assign Sum     = sum_q;
  assign Cout    = cout_q;
  assign Invalid = invalid_q;
  assign Done    = done_q;
  assign Busy    = (state_q == RUN);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder with DIGITS=4.
`timescale 1ns/1ps
module tb_bcd_serial_adder;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Sub;
  logic [15:0] A, B;
  logic [15:0] Sum;
  logic        Cout, Invalid, Busy, Done;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] last_sum = 16'h0000;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .Sub     (Sub),
    .A       (A),
    .B       (B),
    .Sum     (Sum),
    .Cout    (Cout),
    .Invalid (Invalid),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one operation from the current cycle and follows it to Done.
  // With poke set, a second Start with other operands is driven one cycle into RUN.
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] es, input logic ec,
                       input logic ei, input logic poke);
    int n;
    A = a; B = b; Sub = s; Start = 1'b1;
    tick();
    Start = 1'b0;
    A = ~a; B = ~b; Sub = ~s;
    check({name, "_done_pulse"}, Done, 0);
    n = 0;
    while (Done !== 1'b1 && n < 20) begin
      check({name, "_busy"}, Busy, (!ei && n < 4));
      check({name, "_sum_hold"}, Sum, last_sum);
      if (poke && n == 1) begin
        Start = 1'b1; A = 16'h1111; B = 16'h2222; Sub = 1'b1;
      end else begin
        Start = 1'b0;
      end
      tick();
      n++;
    end
    Start = 1'b0;
    check({name, "_latency"}, n, ei ? 1 : 5);
    check({name, "_sum"}, Sum, es);
    check({name, "_cout"}, Cout, ec);
    check({name, "_invalid"}, Invalid, ei);
    check({name, "_busy_end"}, Busy, 0);
    last_sum = es;
  endtask

  initial begin
    bit seen_done;
    Reset = 1'b1; Start = 1'b0; Sub = 1'b0; A = '0; B = '0;
    #1;
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
    check("rst_invalid", Invalid, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    repeat (2) tick();
    Reset = 1'b0;
    tick();

    do_op("add_4567_5678", 16'h4567, 16'h5678, 1'b0, 16'h0245, 1'b1, 1'b0, 1'b0);
    do_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    do_op("sub_1000_0001", 16'h1000, 16'h0001, 1'b1, 16'h0999, 1'b0, 1'b0, 1'b0);
    do_op("sub_0001_0002", 16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0);
    do_op("invalid_00a0", 16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    do_op("start_in_run", 16'h4567, 16'h5678, 1'b0, 16'h0245, 1'b1, 1'b0, 1'b1);
    do_op("start_in_done", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

    // Abort two cycles into RUN with an asynchronous reset between edges.
    A = 16'h4567; B = 16'h5678; Sub = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    #2 Reset = 1'b1;
    #1;
    check("abort_sum", Sum, 0);
    check("abort_cout", Cout, 0);
    check("abort_invalid", Invalid, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    tick();
    Reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (Done === 1'b1) seen_done = 1'b1;
      tick();
    end
    check("abort_no_done", seen_done, 0);
    last_sum = 16'h0000;

    do_op("add_0012_0034", 16'h0012, 16'h0034, 1'b0, 16'h0046, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
